// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data memory.
package dmem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // IDLE: nothing pending. RESP: a response is being held for the consumer.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Natural alignment check. Bytes are always aligned. The reserved size is
  // flagged separately by the caller.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane logic for sized accesses. Lane k always corresponds to the byte at
// address addr+k, so steering reduces to enables plus extension.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rbytes,
  output logic [3:0]  byte_en,
  output logic [31:0] wbytes,
  output logic [31:0] rdata_ext
);

  // Store side: enable the low 1/2/4 lanes; reserved size writes nothing.
  always_comb begin
    byte_en = 4'b0000;
    case (size)
      SZ_BYTE: byte_en = 4'b0001;
      SZ_HALF: byte_en = 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    wbytes = '0;
    for (int k = 0; k < 4; k++) begin
      wbytes[8*k +: 8] = byte_en[k] ? wdata[8*k +: 8] : 8'h00;
    end
  end

  // Load side: keep the low lanes and extend; word ignores is_unsigned.
  always_comb begin
    rdata_ext = '0;
    case (size)
      SZ_BYTE: rdata_ext = is_unsigned ? {24'h000000, rbytes[7:0]}
                                       : {{24{rbytes[7]}}, rbytes[7:0]};
      SZ_HALF: rdata_ext = is_unsigned ? {16'h0000, rbytes[15:0]}
                                       : {{16{rbytes[15]}}, rbytes[15:0]};
      SZ_WORD: rdata_ext = rbytes;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed little-endian data memory with byte/half/word accesses and
// a single-outstanding request/response handshake.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where rsp_valid && rsp_ready. rsp_valid,
// rsp_rdata and rsp_err stay stable until the response transfers. While a
// response is held, a new request is only taken in the same cycle that the
// held response transfers, giving one access per cycle back-to-back.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int    ADDR_BITS        = 8,
  parameter string INIT_FILE        = "",
  parameter bit    ALLOW_MISALIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic                 accept;
  logic                 req_err;
  logic                 do_write;
  logic [ADDR_BITS-1:0] lane_addr [4];
  logic [31:0]          rbytes;
  logic [3:0]           byte_en;
  logic [31:0]          wbytes;
  logic [31:0]          rdata_ext;

  // Address bits above ADDR_BITS are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  // Lane addresses wrap modulo the depth; gather the four read lanes.
  always_comb begin
    rbytes = '0;
    for (int k = 0; k < 4; k++) begin
      lane_addr[k]     = req_addr[ADDR_BITS-1:0] + ADDR_BITS'(k);
      rbytes[8*k +: 8] = mem[lane_addr[k]];
    end
  end

  // Reserved size always errors; misalignment errors unless allowed.
  always_comb begin
    req_err = (req_size == SZ_RSVD) ||
              (!ALLOW_MISALIGNED && is_misaligned(req_size, req_addr[1:0]));
  end

  dmem_align u_align (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rbytes      (rbytes),
    .byte_en     (byte_en),
    .wbytes      (wbytes),
    .rdata_ext   (rdata_ext)
  );

  // Next state, request acceptance and the response to be registered.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b1;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_RESP: req_ready = rsp_ready;
      default: req_ready = 1'b1;
    endcase
    accept = req_valid && req_ready;
    if (accept) begin
      state_d     = ST_RESP;
      rsp_err_d   = req_err;
      rsp_rdata_d = (req_err || req_we) ? 32'h0 : rdata_ext;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      state_d = ST_IDLE;
    end
    do_write = accept && req_we && !req_err;
  end

  // FSM and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte array write; contents survive reset, but a store in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[lane_addr[k]] <= wbytes[8*k +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
